// File: rtl/adc_sar_sequencer.sv
// Purpose : SAR ADC conversion sequencer and binary capacitor-array switch controller.
// Latency : start captured at edge t0 -> eoc in cycle t0+SAMPLE_CYCLES+N+1; period SAMPLE_CYCLES+N+2.
// Backpr. : none; start is a level request sampled only in S_IDLE/S_DONE and never queued.
//
// Ports:
//   i_clk            conversion clock, rising edge
//   i_rstb           asynchronous active-low reset
//   i_start          level conversion request (sampled in S_IDLE and S_DONE)
//   i_cmp            comparator decision, 1 = DAC level above the held input
//   i_abort          (ADC_SAR_SEQ_ABORT_EN only) cancel a running conversion
//   o_sample         track switch enable
//   o_dac_ctrl       capacitor switch word, bit set = capacitor tied to vref
//   o_current_state  FSM state code, consumed by the reconstruction block
//   o_busy           high in every state except S_IDLE
//   o_eoc            one-cycle end-of-conversion pulse (S_DONE)
//   o_dout           last conversion result, held until the next S_DONE
//   o_dout_valid     sticky, set at the first S_DONE after reset
//
// Optional feature macro: ADC_SAR_SEQ_ABORT_EN (adds i_abort). All outputs are registered.

module adc_sar_sequencer #(
    parameter int N             = 8,
    parameter int STATE_SIZE    = 4,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstb,
    input  logic                  i_start,
    input  logic                  i_cmp,
`ifdef ADC_SAR_SEQ_ABORT_EN
    input  logic                  i_abort,
`endif
    output logic                  o_sample,
    output logic [N-1:0]          o_dac_ctrl,
    output logic [STATE_SIZE-1:0] o_current_state,
    output logic                  o_busy,
    output logic                  o_eoc,
    output logic [N-1:0]          o_dout,
    output logic                  o_dout_valid
);

    // State codes shared with the reconstruction block.
    typedef enum logic [STATE_SIZE-1:0] {
        S_IDLE         = STATE_SIZE'(0),
        S_SAMPLE       = STATE_SIZE'(1),
        S_EXTRA_SAMPLE = STATE_SIZE'(2),
        S_CONV         = STATE_SIZE'(3),
        S_DONE         = STATE_SIZE'(4)
    } state_t;

    localparam int             CW       = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int             KW       = $clog2(N);
    localparam logic [N-1:0]   ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   MIDSCALE = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0]  CNT_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [KW-1:0]  K_MSB    = KW'(N - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;        // remaining track cycles after the current one
    logic [KW-1:0]   r_k;          // bit currently under trial
    logic [N-1:0]    r_dac;
    logic            r_sample;
    logic            r_busy;
    logic            r_eoc;
    logic [N-1:0]    r_dout;
    logic            r_dout_valid;

    logic            w_abort;
    logic [N-1:0]    w_kbit;       // one-hot of the bit under trial
    logic [N-1:0]    w_next_kbit;  // one-hot of the next lower bit
    logic [N-1:0]    w_resolved;   // switch word with bit k decided by the comparator

`ifdef ADC_SAR_SEQ_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Comparator high means the trial level overshoots the input, so the
    // trial bit is dropped; otherwise it is kept.
    always_comb begin
        w_kbit      = ONE << r_k;
        w_next_kbit = w_kbit >> 1;
        w_resolved  = i_cmp ? (r_dac & ~w_kbit) : r_dac;
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_k          <= '0;
            r_dac        <= MIDSCALE;
            r_sample     <= 1'b0;
            r_busy       <= 1'b0;
            r_eoc        <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            // eoc is a single-cycle pulse; only the last trial step raises it.
            r_eoc <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_dac    <= MIDSCALE;
                    r_sample <= 1'b0;
                    if (i_start) begin
                        r_state  <= S_SAMPLE;
                        r_sample <= 1'b1;
                        r_cnt    <= CNT_LOAD;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end

                S_SAMPLE: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_sample <= 1'b0;
                        r_dac    <= MIDSCALE;
                        r_busy   <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state  <= S_EXTRA_SAMPLE;
                        r_sample <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt - CW'(1);
                    end
                end

                // One settle cycle with the track switch open before the
                // first trial; the DAC stays at midscale.
                S_EXTRA_SAMPLE: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_sample <= 1'b0;
                        r_dac    <= MIDSCALE;
                        r_busy   <= 1'b0;
                    end else begin
                        r_state  <= S_CONV;
                        r_k      <= K_MSB;
                        r_dac    <= MIDSCALE;
                    end
                end

                // The first trial word (MSB only) equals midscale, so the
                // settle cycle already presents it.
                S_CONV: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_sample <= 1'b0;
                        r_dac    <= MIDSCALE;
                        r_busy   <= 1'b0;
                    end else if (r_k == '0) begin
                        r_state      <= S_DONE;
                        r_dac        <= w_resolved;
                        r_dout       <= w_resolved;
                        r_dout_valid <= 1'b1;
                        r_eoc        <= 1'b1;
                    end else begin
                        r_dac <= w_resolved | w_next_kbit;
                        r_k   <= r_k - KW'(1);
                    end
                end

                // A held start chains straight into the next track phase.
                S_DONE: begin
                    r_dac <= MIDSCALE;
                    if (i_start) begin
                        r_state  <= S_SAMPLE;
                        r_sample <= 1'b1;
                        r_cnt    <= CNT_LOAD;
                    end else begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                // Illegal codes recover to idle with every output at its
                // reset value.
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_k          <= '0;
                    r_dac        <= MIDSCALE;
                    r_sample     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_sample        = r_sample;
    assign o_dac_ctrl      = r_dac;
    assign o_current_state = r_state;
    assign o_busy          = r_busy;
    assign o_eoc           = r_eoc;
    assign o_dout          = r_dout;
    assign o_dout_valid    = r_dout_valid;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Purpose : self-checking bench for adc_sar_sequencer (N=8, SAMPLE_CYCLES=2).
// Latency : n/a (bench).
// Backpr. : n/a (bench).

module tb_adc_sar_sequencer;

    localparam int N       = 8;
    localparam int SS      = 4;
    localparam int SC      = 2;
    localparam int DONE_PH = SC + N + 1;
    localparam logic [N-1:0] MID = 8'h80;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          start = 1'b0;
    logic          cmp;
    logic          noise = 1'b0;
    logic [N-1:0]  target = '0;
`ifdef ADC_SAR_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic          o_sample;
    logic [N-1:0]  o_dac_ctrl;
    logic [SS-1:0] o_current_state;
    logic          o_busy;
    logic          o_eoc;
    logic [N-1:0]  o_dout;
    logic          o_dout_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_sar_sequencer #(.N(N), .STATE_SIZE(SS), .SAMPLE_CYCLES(SC)) dut (
        .i_clk           (clk),
        .i_rstb          (rstb),
        .i_start         (start),
        .i_cmp           (cmp),
`ifdef ADC_SAR_SEQ_ABORT_EN
        .i_abort         (abort),
`endif
        .o_sample        (o_sample),
        .o_dac_ctrl      (o_dac_ctrl),
        .o_current_state (o_current_state),
        .o_busy          (o_busy),
        .o_eoc           (o_eoc),
        .o_dout          (o_dout),
        .o_dout_valid    (o_dout_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: -1 = idle, otherwise cycles elapsed since the start was taken.
    int           m_phase = -1;
    logic [N-1:0] m_tgt   = '0;
    logic [N-1:0] m_dout  = '0;
    logic         m_dv    = 1'b0;

    function automatic bit in_conv(input int ph);
        return (ph >= SC + 1) && (ph <= SC + N);
    endfunction

    // During trials the comparator compares the DAC against the held input;
    // elsewhere it carries random noise that must be ignored.
    assign cmp = in_conv(m_phase) ? (o_dac_ctrl > m_tgt) : noise;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_phase <= -1;
            m_dout  <= '0;
            m_dv    <= 1'b0;
        end else if (m_phase == -1 || m_phase == DONE_PH) begin
            if (start) begin
                m_phase <= 0;
                m_tgt   <= target;
            end else begin
                m_phase <= -1;
            end
        end
`ifdef ADC_SAR_SEQ_ABORT_EN
        else if (abort) begin
            m_phase <= -1;
        end
`endif
        else begin
            m_phase <= m_phase + 1;
            if (m_phase + 1 == DONE_PH) begin
                m_dout <= m_tgt;
                m_dv   <= 1'b1;
            end
        end
    end

    // Trial word for bit k: the target's bits above k are resolved, bit k set.
    function automatic logic [N-1:0] exp_dac(input int ph, input logic [N-1:0] t);
        int k;
        int v;
        if (in_conv(ph)) begin
            k = N - 1 - (ph - SC - 1);
            v = (int'(t) >> (k + 1)) << (k + 1);
            v = v | (1 << k);
            return v[N-1:0];
        end
        if (ph == DONE_PH) return t;
        return MID;
    endfunction

    function automatic logic [SS-1:0] exp_state(input int ph);
        if (ph < 0)       return 4'd0;
        if (ph < SC)      return 4'd1;
        if (ph == SC)     return 4'd2;
        if (in_conv(ph))  return 4'd3;
        return 4'd4;
    endfunction

    always @(negedge clk) begin
        check("m_state", o_current_state, exp_state(m_phase));
        check("m_sample", o_sample, (m_phase >= 0) && (m_phase < SC));
        check("m_dac", o_dac_ctrl, exp_dac(m_phase, m_tgt));
        check("m_busy", o_busy, m_phase != -1);
        check("m_eoc", o_eoc, m_phase == DONE_PH);
        check("m_dout", o_dout, m_dout);
        check("m_dout_valid", o_dout_valid, m_dv);
    end

    // ---------------- directed tasks ----------------
    task automatic conv_directed(input logic [N-1:0] tgt, input bit chk_seq);
        logic [N-1:0] dac_log [0:12];
        logic         s_log [0:12];
        logic         e_log [0:12];
        logic         b_log [0:12];
        logic [N-1:0] d_log [0:12];
        logic         v_log [0:12];
        logic [7:0]   seq [0:7];
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        @(posedge clk); #1; target = tgt; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int j = 0; j < 13; j++) begin
            @(negedge clk);
            dac_log[j] = o_dac_ctrl; s_log[j] = o_sample; e_log[j] = o_eoc;
            b_log[j] = o_busy; d_log[j] = o_dout; v_log[j] = o_dout_valid;
        end
        check("d_sample0", s_log[0], 1'b1);
        check("d_sample1", s_log[1], 1'b1);
        check("d_sample2", s_log[2], 1'b0);
        for (int j = 0; j < 13; j++) check($sformatf("d_eoc_j%0d", j), e_log[j], j == 11);
        check("d_dout", d_log[11], tgt);
        check("d_dout_valid", v_log[11], 1'b1);
        check("d_busy_done", b_log[11], 1'b1);
        check("d_busy_after", b_log[12], 1'b0);
        if (chk_seq) begin
            for (int i = 0; i < 8; i++) check($sformatf("d_seq%0d", i), dac_log[3 + i], seq[i]);
        end
    endtask

    task automatic back_to_back();
        int first;
        int second;
        bit saw_idle;
        first = -1; second = -1; saw_idle = 1'b0;
        @(posedge clk); #1; target = 8'h3C; start = 1'b1;
        for (int c = 0; c < 40 && second < 0; c++) begin
            @(negedge clk);
            if (o_eoc) begin
                if (first < 0) begin
                    first = c;
                    check("b2b_dout0", o_dout, 8'h3C);
                    target = 8'hC3;
                end else begin
                    second = c;
                    check("b2b_dout1", o_dout, 8'hC3);
                    start = 1'b0;
                end
            end else if (first >= 0 && o_current_state == 4'd0) begin
                saw_idle = 1'b1;
            end
        end
        if (second < 0) start = 1'b0;
        check("b2b_first_seen", first >= 0, 1'b1);
        check("b2b_gap", second - first, 12);
        check("b2b_no_idle", saw_idle, 1'b0);
        repeat (3) @(posedge clk);
    endtask

    task automatic mid_reset();
        @(posedge clk); #1; target = 8'h5A; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(negedge clk);
        check("mr_pre_state", o_current_state, 4'd3);
        check("mr_pre_dac", o_dac_ctrl, 8'h50);
        #1 rstb = 1'b0;
        #1;
        check("mr_dac", o_dac_ctrl, 8'h80);
        check("mr_state", o_current_state, 4'd0);
        check("mr_busy", o_busy, 1'b0);
        check("mr_sample", o_sample, 1'b0);
        check("mr_dout", o_dout, 8'h00);
        check("mr_dout_valid", o_dout_valid, 1'b0);
        @(negedge clk); #2 rstb = 1'b1;
        conv_directed(8'h5A, 1'b0);
    endtask

`ifdef ADC_SAR_SEQ_ABORT_EN
    task automatic abort_test();
        conv_directed(8'h11, 1'b0);
        @(posedge clk); #1; target = 8'hE7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(negedge clk);
        check("ab_pre_state", o_current_state, 4'd3);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("ab_state", o_current_state, 4'd0);
        check("ab_eoc", o_eoc, 1'b0);
        check("ab_dout", o_dout, 8'h11);
        check("ab_dout_valid", o_dout_valid, 1'b1);
        check("ab_dac", o_dac_ctrl, 8'h80);
        check("ab_sample", o_sample, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dac", o_dac_ctrl, 8'h80);
        check("rst_dout", o_dout, 8'h00);
        check("rst_dout_valid", o_dout_valid, 1'b0);
        check("rst_state", o_current_state, 4'd0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_sample", o_sample, 1'b0);
        #2 rstb = 1'b1;
        repeat (2) @(posedge clk);

        conv_directed(8'hA5, 1'b1);
        conv_directed(8'h00, 1'b0);
        conv_directed(8'hFF, 1'b0);
        back_to_back();
        mid_reset();
`ifdef ADC_SAR_SEQ_ABORT_EN
        abort_test();
`endif

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            start  = ($urandom_range(0, 3) == 0);
            target = N'($urandom);
            noise  = 1'($urandom);
`ifdef ADC_SAR_SEQ_ABORT_EN
            abort  = ($urandom_range(0, 49) == 0);
`endif
        end
        @(posedge clk); #1;
        start = 1'b0;
`ifdef ADC_SAR_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_sar_sequencer.md
Name: adc_sar_sequencer

Overview:
Conversion sequencer and DAC switch controller for the SAR ADC. It runs the conversion state machine (idle, sample, extra-sample, convert, done) and publishes its state code on current_state, which the reconstruction block consumes. During conversion it drives the binary capacitor-array switch word from the comparator decision, one bit per cycle. It also returns the final code with an end-of-conversion handshake to the digital host.

Parameters:
N, 8, ADC resolution in bits (N >= 2)
STATE_SIZE, 4, width of state code; codes S_IDLE, S_SAMPLE, S_EXTRA_SAMPLE, S_CONV, S_DONE from shared adc_sar_encoding.vh
SAMPLE_CYCLES, 2, number of cycles the track switch is closed (>= 1)

Ports:
clk  input  1  conversion clock, rising edge
rstb  input  1  asynchronous active-low reset
start  input  1  level request; sampled in S_IDLE and S_DONE
cmp  input  1  comparator decision; 1 = DAC level above input
sample  output  1  track switch enable, registered
dac_ctrl  output  N  capacitor switch word; bit set = cap tied to vref, registered
current_state  output  STATE_SIZE  current FSM state code, registered
busy  output  1  high in every state except S_IDLE
eoc  output  1  one-cycle end-of-conversion pulse, high in S_DONE
dout  output  N  last conversion result, held until next S_DONE
dout_valid  output  1  set at first S_DONE after reset, sticky

Behaviour:
- Reset (rstb low, asynchronous): state S_IDLE; sample=0; dac_ctrl=2**(N-1) (midscale); busy=0; eoc=0; dout=0; dout_valid=0. Applies from any state, including mid-conversion. Resumes on the first edge after release.
- S_IDLE: start=1 at an edge -> S_SAMPLE. Otherwise stay.
- S_SAMPLE: sample=1 for exactly SAMPLE_CYCLES cycles; internal counter then -> S_EXTRA_SAMPLE.
- S_EXTRA_SAMPLE: 1 cycle, sample=0, dac_ctrl=midscale (comparator settle) -> S_CONV, bit index k=N-1.
- S_CONV: N cycles, k = N-1 down to 0.
  - dac_ctrl = resolved upper bits | (1<<k); bits below k are 0.
  - At the cycle-ending edge, cmp is captured: cmp=0 keeps bit k, cmp=1 clears it.
  - After k=0 -> S_DONE.
- S_DONE: 1 cycle.
  - eoc=1; dout loads the fully resolved word; dout_valid=1; dac_ctrl holds the result.
  - Next state: start=1 -> S_SAMPLE (back-to-back, no S_IDLE cycle); start=0 -> S_IDLE.
- In S_IDLE, S_SAMPLE and S_EXTRA_SAMPLE, dac_ctrl is forced to midscale, matching the reconstruction weight preset.
- Latency: start captured at edge t0; eoc is high in the cycle beginning at edge t0+SAMPLE_CYCLES+N+1. Conversion period is SAMPLE_CYCLES+N+2 cycles.
- start is ignored in S_SAMPLE, S_EXTRA_SAMPLE and S_CONV. It is not queued.
- cmp is ignored outside S_CONV.
- Boundaries: cmp always 1 -> dout=0x00. cmp always 0 -> dout=2**N-1.
- Unused state codes decode to S_IDLE on the next edge, with outputs forced to their reset values.

Optional Feature:
ADC_SAR_SEQ_ABORT_EN:
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge in S_SAMPLE, S_EXTRA_SAMPLE or S_CONV -> S_IDLE next cycle, with sample=0 and dac_ctrl=midscale.
  - No eoc pulse; dout and dout_valid are unchanged.
  - abort in S_DONE has no effect on that result.
  - abort has priority over start.
- Undefined: no abort port; conversions always run to completion.

Test Plan:
- Reset values: rstb=0 -> dac_ctrl=0x80, dout=0x00, dout_valid=0, current_state=S_IDLE, busy=0, sample=0.
- Single conversion, N=8, SAMPLE_CYCLES=2, bench model cmp=(dac_ctrl>0xA5):
  - sample high 2 cycles.
  - dac_ctrl sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - eoc high at t0+11 for 1 cycle; dout=0xA5; dout_valid=1.
- Extremes: target 0x00 (cmp always 1) -> dout=0x00. Target 0xFF (cmp always 0) -> dout=0xFF. busy low one cycle after eoc when start=0.
- Back-to-back: start held high, targets 0x3C then 0xC3 -> two eoc pulses 12 cycles apart, no S_IDLE between, dout=0x3C then 0xC3.
- Mid-conversion reset: rstb pulsed low during S_CONV k=4 -> immediate reset values. Next start yields a correct full conversion of 0x5A.
- (ADC_SAR_SEQ_ABORT_EN) abort at S_CONV k=3 after a prior result 0x11 -> S_IDLE next cycle, no eoc, dout stays 0x11.
